// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited word requests to imem,
// and queues returned words with their PCs for decode; redirects flush and drop in-flight.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          fifo_mem [FIFO_DEPTH];
  entry_t          head;
  logic [31:0]     pc, rsp_pc, redir_tgt;
  logic [CW-1:0]   outstanding, outstanding_next, drop, count;
  logic [PW-1:0]   wptr, rptr;
  logic [CW:0]     inflight;
  logic            run, fire, push, pop;

  // run keeps imem_req low for the first cycle after reset
  assign inflight  = {1'b0, outstanding} + {1'b0, count};
  assign imem_req  = run && !redirect_valid && (inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = pc;
  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;

  assign fire = imem_req && imem_gnt;
  assign pop  = instr_valid && instr_ready;
  // a response landing in the redirect cycle is stale by definition
  assign push = imem_rvalid && (drop == '0) && !redirect_valid;

  assign outstanding_next = outstanding + CW'(fire) - CW'(imem_rvalid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      run         <= 1'b0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        pc     <= redir_tgt;
        rsp_pc <= redir_tgt;
        drop   <= outstanding_next;
        count  <= '0;
        wptr   <= '0;
        rptr   <= '0;
      end else begin
        if (fire) pc <= pc + 32'd4;
        if (imem_rvalid && (drop != '0)) drop <= drop - CW'(1);
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wptr   <= wptr + PW'(1);
        end
        if (pop) rptr <= rptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // PC of each kept response follows from the last redirect/reset target
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= '{instr: imem_rdata, pc: rsp_pc};
  end

  assign head        = fifo_mem[rptr];
  assign instr_valid = (count != '0);
  assign instr_o     = head.instr;
  assign pc_o        = head.pc;
  assign opcode_o    = head.instr[6:0];
  assign funct3_o    = head.instr[14:12];
  assign funct7_o    = head.instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order memory model, expected PCs queued at grant,
// popped and compared at each decode handshake.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_o, pc_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [2:0]  funct3_o;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_o(instr_o), .pc_o(pc_o),
    .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o)
  );

  int          n_chk = 0, n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mem_q [$];
  logic [31:0] nxt_pc = 32'h0;
  logic [31:0] e, w;
  bit          resp_en = 1'b1, rand_gap = 1'b0, prev_rst_low = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // memory: answers granted requests in order, one or more cycles later
  always @(negedge clk) begin
    if (rst_n && resp_en && mem_q.size() != 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // monitor samples 1 time unit before each rising edge
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      if (prev_rst_low) begin
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      end
      prev_rst_low = 1'b1;
      exp_q.delete();
      mem_q.delete();
      nxt_pc = 32'h0;
    end else begin
      prev_rst_low = 1'b0;
      if (instr_valid && instr_ready) begin
        chk("hs_expected", {31'b0, exp_q.size() != 0}, 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          w = word_of(e);
          chk("pc_o", pc_o, e);
          chk("instr_o", instr_o, w);
          chk("opcode", {25'b0, opcode_o}, {25'b0, w[6:0]});
          chk("funct3", {29'b0, funct3_o}, {29'b0, w[14:12]});
          chk("funct7", {25'b0, funct7_o}, {25'b0, w[31:25]});
        end
      end
      if (redirect_valid) begin
        chk("req_in_redirect", {31'b0, imem_req}, 32'h0);
        exp_q.delete();
        nxt_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (imem_req && imem_gnt) begin
        chk("imem_addr", imem_addr, nxt_pc);
        exp_q.push_back(nxt_pc);
        mem_q.push_back(imem_addr);
        nxt_pc = nxt_pc + 32'd4;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic redir(input logic [31:0] tgt);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int k = 0;
    while (k < bound) begin
      @(negedge clk);
      #4;
      if (instr_valid) break;
      k++;
    end
    chk(tag, {31'b0, instr_valid}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    cyc(3);

    // 1: streaming from reset
    rst_n = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
    cyc(20);

    // 2: decode stalls, buffer fills, issue stops, head holds
    instr_ready = 1'b0;
    cyc(8); #4;
    chk("t2_req_full", {31'b0, imem_req}, 32'h0);
    chk("t2_valid", {31'b0, instr_valid}, 32'h1);
    chk("t2_head_pc", pc_o, exp_q[0]);
    cyc(3); #4;
    chk("t2_hold_pc", pc_o, exp_q[0]);
    chk("t2_hold_instr", instr_o, word_of(exp_q[0]));
    @(negedge clk);
    instr_ready = 1'b1;
    cyc(10);

    // 3: two requests in flight, then redirect; both responses must be dropped
    resp_en = 1'b0;
    cyc(5); #4;
    chk("t3_req_stall", {31'b0, imem_req}, 32'h0);
    redir(32'h0000_0100);
    resp_en = 1'b1;
    wait_valid("t3_valid_timeout", 40);
    chk("t3_pc", pc_o, 32'h0000_0100);
    cyc(6);

    // 4: unaligned target and address wrap
    redir(32'h0000_0203);
    #4;
    chk("t4_addr", imem_addr, 32'h0000_0200);
    cyc(6);
    redir(32'hFFFF_FFFC);
    #4;
    chk("t4_wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("t4_valid_timeout", 40);
    chk("t4_wrap_pc", pc_o, 32'hFFFF_FFFC);
    cyc(8);

    // 5: grant withheld; request and address hold
    @(negedge clk);
    imem_gnt = 1'b0;
    cyc(4);
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("t5_req", {31'b0, imem_req}, 32'h1);
      chk("t5_addr", imem_addr, nxt_pc);
      @(negedge clk);
    end
    imem_gnt = 1'b1;
    cyc(10);

    // random traffic with random redirects
    rand_gap = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      imem_gnt       = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
    end
    @(negedge clk);
    redirect_valid = 1'b0; rand_gap = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
    cyc(10);

    // 6: reset with two requests outstanding, no responses afterwards
    resp_en = 1'b0;
    cyc(5);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1; resp_en = 1'b1;
    wait_valid("t6_valid_timeout", 40);
    chk("t6_restart_pc", pc_o, 32'h0000_0000);
    cyc(20);

    // drain
    @(negedge clk);
    imem_gnt = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
